// File: rtl/umtrx_stream_pkg.sv
// Shared definitions for sys-domain 36-bit VITA word streams:
// field positions, merge FSM encoding and word-field helpers.
package umtrx_stream_pkg;

    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;
    localparam int OCC_LSB = 34;
    localparam int WORD_W  = 36;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } mux_state_e;

    function automatic logic is_sof(input logic [WORD_W-1:0] w);
        return w[SOF_BIT];
    endfunction

    function automatic logic is_eof(input logic [WORD_W-1:0] w);
        return w[EOF_BIT];
    endfunction

endpackage

// File: rtl/umtrx_stream_skid.sv
// Two-entry skid buffer with registered data, valid and ready.
// Reusable for any sys-domain valid/ready stream stage.
module umtrx_stream_skid #(
    parameter int WIDTH = 36
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_head, r_tail, w_head_n, w_tail_n;
    logic             r_hv, r_tv, w_hv_n, w_tv_n, r_rdy;
    logic             w_push, w_pop;

    assign w_push = i_valid & r_rdy;
    assign w_pop  = r_hv & i_ready;

    always_comb begin
        w_head_n = r_head;
        w_tail_n = r_tail;
        w_hv_n   = r_hv;
        w_tv_n   = r_tv;
        if (w_pop) begin
            if (r_tv) begin
                w_head_n = r_tail;
                w_tv_n   = w_push;
                if (w_push)
                    w_tail_n = i_data;
            end else if (w_push) begin
                w_head_n = i_data;
            end else begin
                w_hv_n = 1'b0;
            end
        end else if (w_push) begin
            if (!r_hv) begin
                w_head_n = i_data;
                w_hv_n   = 1'b1;
            end else begin
                w_tail_n = i_data;
                w_tv_n   = 1'b1;
            end
        end
    end

    // ready is the next-cycle view of count<2, so it is a flop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_hv   <= 1'b0;
            r_tv   <= 1'b0;
            r_rdy  <= 1'b0;
        end else begin
            r_head <= w_head_n;
            r_tail <= w_tail_n;
            r_hv   <= w_hv_n;
            r_tv   <= w_tv_n;
            r_rdy  <= ~(w_hv_n & w_tv_n);
        end
    end

    assign o_data  = r_head;
    assign o_valid = r_hv;
    assign o_ready = r_rdy;

endmodule

// File: rtl/umtrx_rx_stream_mux.sv
// Packet-atomic round-robin merge of the DSP0/DSP1 RX streams.
// UMTRX_RX_MUX_STATS_EN adds per-port packet and drop counters.
module umtrx_rx_stream_mux
    import umtrx_stream_pkg::*;
#(
    parameter logic PRIO_RESET    = 1'b0,
    parameter int   MAX_PKT_WORDS = 4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [35:0] in0_data,
    input  logic        in0_valid,
    output logic        in0_ready,
    input  logic [35:0] in1_data,
    input  logic        in1_valid,
    output logic        in1_ready,
    output logic [35:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        cur_port,
    output logic        trunc_pulse
`ifdef UMTRX_RX_MUX_STATS_EN
    ,
    output logic [31:0] pkt_cnt0,
    output logic [31:0] pkt_cnt1,
    output logic [15:0] drop_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT_WORDS - 1);

    mux_state_e        r_state, w_state_n;
    logic              r_cur, w_cur_n, r_last, w_last_n;
    logic              r_trunc, w_trunc;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic              w_rdy0, w_rdy1, w_push, w_skid_rdy;
    logic              w_hv, w_c0, w_c1;
    logic [WORD_W-1:0] w_hd, w_push_data;

    assign w_hd = r_cur ? in1_data : in0_data;
    assign w_hv = r_cur ? in1_valid : in0_valid;
    assign w_c0 = in0_valid & is_sof(in0_data);
    assign w_c1 = in1_valid & is_sof(in1_data);

    always_comb begin
        w_state_n   = r_state;
        w_cur_n     = r_cur;
        w_last_n    = r_last;
        w_cnt_n     = r_cnt;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        w_push      = 1'b0;
        w_push_data = w_hd;
        w_trunc     = 1'b0;
        unique case (r_state)
            IDLE: begin
                // gated by skid ready so nothing is popped during reset
                w_rdy0 = w_skid_rdy & in0_valid & ~is_sof(in0_data);
                w_rdy1 = w_skid_rdy & in1_valid & ~is_sof(in1_data);
                if (w_c0 & w_c1) begin
                    w_cur_n   = ~r_last;
                    w_state_n = PASS;
                end else if (w_c0) begin
                    w_cur_n   = 1'b0;
                    w_state_n = PASS;
                end else if (w_c1) begin
                    w_cur_n   = 1'b1;
                    w_state_n = PASS;
                end
            end
            PASS: begin
                if (r_cur) w_rdy1 = w_skid_rdy;
                else       w_rdy0 = w_skid_rdy;
                if (w_hv & w_skid_rdy) begin
                    w_push  = 1'b1;
                    w_cnt_n = r_cnt + CNT_W'(1);
                    if (is_eof(w_hd)) begin
                        w_last_n  = r_cur;
                        w_cnt_n   = '0;
                        w_state_n = IDLE;
                    end else if (r_cnt == LAST_CNT) begin
                        w_push_data[EOF_BIT] = 1'b1;
                        w_trunc   = 1'b1;
                        w_last_n  = r_cur;
                        w_cnt_n   = '0;
                        w_state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (r_cur) w_rdy1 = 1'b1;
                else       w_rdy0 = 1'b1;
                if (w_hv & is_eof(w_hd))
                    w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_cur   <= PRIO_RESET;
            r_last  <= ~PRIO_RESET;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cur   <= w_cur_n;
            r_last  <= w_last_n;
            r_cnt   <= w_cnt_n;
            r_trunc <= w_trunc;
        end
    end

    umtrx_stream_skid #(.WIDTH(WORD_W)) u_skid (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_data  (w_push_data),
        .i_valid (w_push),
        .o_ready (w_skid_rdy),
        .o_data  (out_data),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

    assign in0_ready   = w_rdy0;
    assign in1_ready   = w_rdy1;
    assign cur_port    = r_cur;
    assign trunc_pulse = r_trunc;

`ifdef UMTRX_RX_MUX_STATS_EN
    logic [31:0] r_pkt0, r_pkt1;
    logic [15:0] r_drop;
    logic        w_done, w_d0, w_d1, w_dd;

    assign w_done = w_push & is_eof(w_push_data);
    assign w_d0   = (r_state == IDLE) & in0_valid & w_rdy0;
    assign w_d1   = (r_state == IDLE) & in1_valid & w_rdy1;
    assign w_dd   = (r_state == DRAIN) & w_hv;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pkt0 <= '0;
            r_pkt1 <= '0;
            r_drop <= '0;
        end else begin
            r_pkt0 <= r_pkt0 + 32'(w_done & ~r_cur);
            r_pkt1 <= r_pkt1 + 32'(w_done & r_cur);
            r_drop <= r_drop + 16'(w_d0) + 16'(w_d1)
                    + 16'(w_dd);
        end
    end

    assign pkt_cnt0 = r_pkt0;
    assign pkt_cnt1 = r_pkt1;
    assign drop_cnt = r_drop;
`endif

endmodule
